block_stream_gen: RTL
=====================

// Module: block_stream_gen
// PURPOSE
//  Transmit side of the block-keyword character stream. Accepts high-level commands
//  (BEGIN, END, WORD, CLOSE_ALL) and serialises them one ASCII byte per accepted beat.
//  Every generated stream is balanced and legal, so the block checker on the receive
//  side reports result=1 once all blocks are closed.
//  Used as stimulus source and as the producer ahead of the checker in the pipeline.
// PARAMETERS
//  DEPTH_W  8  width of nesting counter; max nesting = 2**DEPTH_W-1
//  UPPER    0  1: keywords emitted uppercase ("BEGIN"/"END"), 0: lowercase
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        asynchronous, active-low reset
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        block can accept a command this cycle
//  cmd        in   2        00 BEGIN, 01 END, 10 WORD, 11 CLOSE_ALL
//  cmd_char   in   8        character for WORD; ignored otherwise
//  out        out  8        ASCII byte
//  out_valid  out  1        out holds a stream byte
//  out_ready  in   1        consumer takes the byte this cycle
//  depth      out  DEPTH_W  current open-block count
//  err        out  1        one-cycle pulse: command rejected
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, out=8'h20, out_valid=0, cmd_ready=1, depth=0,
//   err=0, byte index=0.
//  Tokens are always space-delimited on both sides:
//   BEGIN=" begin " (7 bytes), END=" end " (5 bytes), WORD=" c " (3 bytes).
//  Accept = cmd_valid & cmd_ready. cmd_ready=1 only in IDLE.
//  FSM states: IDLE, EMIT, CLOSE.
//   IDLE: on accept of a legal BEGIN/END/WORD, latch the token and go to EMIT.
//    The first byte is out_valid in the next cycle (latency 1).
//    BEGIN: depth+1 in the accept cycle. END: depth-1 in the accept cycle.
//   EMIT: out/out_valid held stable until out_ready=1. Each out_ready=1 advances the
//    index one byte. When the last byte is taken, go to IDLE; out_valid=0 and
//    cmd_ready=1 in the next cycle (no back-to-back overlap, one idle cycle per token).
//   CLOSE: emit " end " repeatedly. depth-1 when each token's last byte is taken.
//    Return to IDLE when depth reaches 0.
//  Rejections: the command is consumed, no bytes are emitted, depth is unchanged,
//   err=1 in the next cycle only. Rejected cases:
//   - END at depth 0;
//   - BEGIN at depth 2**DEPTH_W-1;
//   - WORD with cmd_char == 8'h20.
//  CLOSE_ALL at depth 0: accepted, no bytes, no err, stays IDLE.
//  out_valid=0 -> out=8'h20 (a space is harmless to the checker).
//  cmd_valid while cmd_ready=0: ignored. The producer must hold the command.
//  out_ready while out_valid=0: ignored.
//  depth never wraps; the guards above prevent overflow and underflow.
//  Reset mid-token: immediate abort to reset values; partial token bytes are not resent.
// TESTING
//  1 reset, BEGIN, out_ready=1 -> bytes 20 62 65 67 69 6E 20 on cycles 2..8;
//    depth=1 from cycle 2.
//  2 BEGIN,BEGIN,WORD 'x',END,END fed to checker, out_ready=1 -> checker result=1 at
//    end; depth sequence 1,2,2,1,0.
//  3 END at depth 0 -> err=1 for exactly 1 cycle, out_valid stays 0, depth=0.
//  4 BEGIN x3 then CLOSE_ALL -> three " end " tokens (15 bytes); depth 3->2->1->0;
//    cmd_ready returns 1 after the last byte.
//  5 BEGIN with out_ready toggling 1,0,1,0 -> each byte held while out_ready=0;
//    no byte lost or duplicated.
//  6 reset asserted mid-BEGIN after 3 bytes -> out_valid=0, depth=0, cmd_ready=1
//    immediately (async).
//  7 UPPER=1, BEGIN -> 20 42 45 47 49 4E 20.

Source files
------------

// File: rtl/block_stream_gen.sv
// Transmit side of the block-keyword stream: turns BEGIN/END/WORD/CLOSE_ALL commands
// into space-delimited ASCII tokens, one byte per accepted beat, never unbalanced.
module block_stream_gen #(
  parameter int DEPTH_W = 8,
  parameter bit UPPER   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd,
  input  logic [7:0]         cmd_char,
  output logic [7:0]         out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] depth,
  output logic               err
);

  localparam logic [1:0] CMD_BEGIN = 2'b00;
  localparam logic [1:0] CMD_END   = 2'b01;
  localparam logic [1:0] CMD_WORD  = 2'b10;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, CLOSE = 2'd2} state_t;

  state_t     state;
  logic [1:0] tok;
  logic [7:0] tok_char;
  logic [2:0] idx;
  logic       start_s;
  logic       reject_s;
  logic       close_s;

  function automatic logic [7:0] kw(input logic [7:0] lc);
    return UPPER ? (lc - 8'h20) : lc;
  endfunction

  // Byte 0 and the final byte of every token are spaces.
  function automatic logic [7:0] tok_byte(input logic [1:0] t, input logic [2:0] i,
                                          input logic [7:0] ch);
    logic [7:0] b;
    b = 8'h20;
    case (t)
      CMD_BEGIN: case (i)
        3'd1:    b = kw(8'h62);
        3'd2:    b = kw(8'h65);
        3'd3:    b = kw(8'h67);
        3'd4:    b = kw(8'h69);
        3'd5:    b = kw(8'h6E);
        default: b = 8'h20;
      endcase
      CMD_END: case (i)
        3'd1:    b = kw(8'h65);
        3'd2:    b = kw(8'h6E);
        3'd3:    b = kw(8'h64);
        default: b = 8'h20;
      endcase
      CMD_WORD: b = (i == 3'd1) ? ch : 8'h20;
      default:  b = 8'h20;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] t);
    case (t)
      CMD_BEGIN: return 3'd6;
      CMD_END:   return 3'd4;
      default:   return 3'd2;
    endcase
  endfunction

  // Classify an accepted command: emit a token, start closing, or reject.
  always_comb begin
    start_s  = 1'b0;
    reject_s = 1'b0;
    close_s  = 1'b0;
    if (cmd_valid && cmd_ready) begin
      case (cmd)
        CMD_BEGIN: if (depth == DEPTH_MAX) reject_s = 1'b1; else start_s = 1'b1;
        CMD_END:   if (depth == DEPTH_ZERO) reject_s = 1'b1; else start_s = 1'b1;
        CMD_WORD:  if (cmd_char == 8'h20) reject_s = 1'b1; else start_s = 1'b1;
        default:   if (depth != DEPTH_ZERO) close_s = 1'b1; else close_s = 1'b0;
      endcase
    end else begin
      start_s = 1'b0;
    end
  end

  // Command FSM and byte serialiser; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tok       <= CMD_BEGIN;
      tok_char  <= 8'h20;
      idx       <= 3'd0;
      out       <= 8'h20;
      out_valid <= 1'b0;
      cmd_ready <= 1'b1;
      depth     <= DEPTH_ZERO;
      err       <= 1'b0;
    end else begin
      err <= reject_s;
      case (state)
        IDLE: begin
          if (start_s || close_s) begin
            tok       <= close_s ? CMD_END : cmd;
            tok_char  <= cmd_char;
            idx       <= 3'd0;
            out       <= 8'h20;
            out_valid <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= close_s ? CLOSE : EMIT;
            if (start_s && cmd == CMD_BEGIN) depth <= depth + DEPTH_ONE;
            else if (start_s && cmd == CMD_END) depth <= depth - DEPTH_ONE;
          end
        end
        EMIT, CLOSE: begin
          if (out_ready) begin
            if (idx == last_idx(tok)) begin
              idx <= 3'd0;
              if (state == CLOSE) depth <= depth - DEPTH_ONE;
              // While closing, the next " end " begins right away with its leading space.
              if (state == CLOSE && depth != DEPTH_ONE) begin
                out <= 8'h20;
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out       <= 8'h20;
                cmd_ready <= 1'b1;
              end
            end else begin
              idx <= idx + 3'd1;
              out <= tok_byte(tok, idx + 3'd1, tok_char);
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out       <= 8'h20;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
